// File: rtl/uart_pkg.sv
// Shared UART definitions: receive state encoding and frame-format constants.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer with asynchronous reset to a selectable level.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receive engine: 16x oversampled 8N1 deserializer with full/overrun/framing status.
import uart_pkg::*;

module uart_rx #(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 baud_tick_i,
  input  logic                 rx_i,
  input  logic                 rd_ack_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_full_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 rx_busy_o
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 full_q, full_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;
  logic                 rx_s;
  logic                 complete;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      full_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      full_q  <= full_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    full_d   = full_q;
    ferr_d   = ferr_q;
    ovr_d    = ovr_q;
    complete = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (baud_tick_i && !rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      // Confirm the start bit at its midpoint; a high sample is a glitch.
      START: begin
        if (baud_tick_i) begin
          if (tick_q == HALF_M1) begin
            if (!rx_s) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (baud_tick_i) begin
          if (tick_q == FULL_M1) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 4'd1;
            tick_d  = '0;
            if (bit_q == LAST_BIT) state_d = STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (baud_tick_i) begin
          if (tick_q == FULL_M1) begin
            complete = 1'b1;
            tick_d   = '0;
            state_d  = rx_s ? IDLE : WAIT_HIGH;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      WAIT_HIGH: begin
        if (baud_tick_i && rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A completing frame takes priority over a concurrent read acknowledge.
    if (complete) begin
      if (!full_q || rd_ack_i) begin
        data_d = shift_q;
        full_d = 1'b1;
        ferr_d = ~rx_s;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rd_ack_i) begin
      full_d = 1'b0;
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign rx_data_o   = data_q;
  assign rx_full_o   = full_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign rx_busy_o   = busy_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receive engine for the UART. It samples RX at 16x the baud rate, using the tick pulse from the baud-rate divisor. It assembles 8N1 frames LSB first and presents each completed byte, with status flags, to the data and status registers. It sits between the RX pin and the CPU-facing register file, directly upstream of the data register.

Parameters:
OVERSAMPLE, 16, BAUD_TICK pulses per bit period; must be even and at least 4
DATA_BITS, 8, data bits per frame; fixed 8N1, no parity

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  asynchronous, active-high reset
BAUD_TICK  input  1  one-CLK-wide pulse at OVERSAMPLE x baud rate
RX  input  1  asynchronous serial input; idle high
RD_ACK  input  1  one-CLK pulse when the CPU reads the data register; clears flags
RX_DATA  output  8  last accepted byte
RX_FULL  output  1  RX_DATA holds an unread byte
FRAME_ERR  output  1  stop bit of the last loaded frame sampled 0
OVERRUN  output  1  a frame completed while RX_FULL=1; that frame was dropped
RX_BUSY  output  1  high in any state other than IDLE

Behaviour:
- Reset (async): state=IDLE, RX_DATA=8'h00, RX_FULL=0, FRAME_ERR=0, OVERRUN=0, RX_BUSY=0, bit/tick counters=0, both synchronizer flops=1.
- RX passes through a 2-flop synchronizer (rx_s). All decisions use rx_s and act only on cycles where BAUD_TICK=1. The tick counter advances only on BAUD_TICK.
- IDLE: on a tick with rx_s=0, go to START and set tick_cnt=0.
- START: on each tick, tick_cnt++. When tick_cnt reaches OVERSAMPLE/2-1 (7):
  - if rx_s=0, go to DATA with tick_cnt=0 and bit_cnt=0;
  - otherwise it is a false start: go to IDLE.
- DATA: on each tick, tick_cnt++. When tick_cnt reaches OVERSAMPLE-1:
  - shift rx_s into the MSB of the shift register (so bit 0 lands in RX_DATA[0] after 8 shifts);
  - bit_cnt++ and tick_cnt=0;
  - after bit_cnt reaches DATA_BITS, go to STOP.
- STOP: when tick_cnt reaches OVERSAMPLE-1, complete the frame (see the load rules below).
  - If the stop sample is 1, go to IDLE.
  - If it is 0, go to WAIT_HIGH.
- WAIT_HIGH (break / framing recovery): stay until a tick with rx_s=1, then go to IDLE. No start is accepted in this state.
- Frame-completion load rules, evaluated on the completing tick cycle. Outputs update one CLK later.
  - If RX_FULL=0 or RD_ACK=1 on the same cycle: RX_DATA=shift register, RX_FULL=1, FRAME_ERR=~stop_sample, OVERRUN unchanged. Load wins over the ack, so RX_FULL stays 1.
  - If RX_FULL=1 and RD_ACK=0: RX_DATA is unchanged, OVERRUN=1, FRAME_ERR unchanged. The frame is discarded.
- RD_ACK with no load on the same cycle: RX_FULL=0, FRAME_ERR=0, OVERRUN=0. Acking while RX_FULL=0 has no effect beyond clearing the flags.
- Latency: from the RX falling edge to RX_BUSY=1 is at most 2 CLK (synchronizer) plus the wait for the next tick. From the mid-stop-bit tick to RX_FULL=1 is 1 CLK.
- Reset mid-frame aborts immediately. A partially received byte is never loaded.
- BAUD_TICK held high continuously is legal; each CLK then counts as one tick.
- The counters never wrap past their compare value. tick_cnt is $clog2(OVERSAMPLE) bits wide and bit_cnt is 4 bits.

Decomposition:
- Shared package uart_pkg: rx_state_t enum {IDLE, START, DATA, STOP, WAIT_HIGH}, plus constants UART_OVERSAMPLE=16 and UART_DATA_BITS=8. The future uart_tx reuses this package.
- One sub-module, sync2: a 2-flop synchronizer with async reset to a parameterized value (1 here).

Test Plan:
- Ticks every 4 CLK, send 8N1 byte 8'hA5 with stop=1 -> RX_DATA=8'hA5, RX_FULL=1 one CLK after the stop mid-tick; FRAME_ERR=0, OVERRUN=0, RX_BUSY returns to 0.
- RX low for 3 ticks then high -> false start; state returns to IDLE, RX_FULL stays 0; a following frame 8'h5A is received correctly.
- Frame 8'h3C with stop=0, then RX held low for 40 ticks -> RX_DATA=8'h3C, FRAME_ERR=1, and no new frame is started until RX returns high.
- Send 8'h11 then 8'h22 with no RD_ACK -> RX_DATA=8'h11, OVERRUN=1. Then pulse RD_ACK -> RX_FULL=0, OVERRUN=0, FRAME_ERR=0.
- Send 8'h11; pulse RD_ACK exactly on the completion cycle of a second frame 8'h77 -> RX_DATA=8'h77, RX_FULL=1, OVERRUN=0.
- Assert RESET during data bit 4 of 8'hFF -> all outputs return to reset values asynchronously; the next frame 8'h81 is received correctly.
